// File: rtl/us_timestep_gen.sv
// us_timestep_gen: microsecond-grid timestep generator.
// After an accepted start it emits a one-cycle step_pulse every period_us
// microseconds, for num_steps steps (0 = until stop), and flags done with
// the final pulse. us_elapsed reports whole microseconds since start.
// Optional macro TS_ACK_EN adds a step_ack input: after each non-final
// step the generator parks in WAIT_ACK until the consumer acknowledges.
module us_timestep_gen #(
    parameter int CLK_PER_US = 125,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period_us,
    input  logic [CNT_W-1:0] num_steps,
    output logic             busy,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_idx,
    output logic             done,
    output logic [CNT_W-1:0] us_elapsed
`ifdef TS_ACK_EN
    ,
    input  logic             step_ack
`endif
);

    // Prescaler is wide enough for the full legal CLK_PER_US range.
    localparam int                 PRESC_W   = 16;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0]   CNT_ONES  = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN
`ifdef TS_ACK_EN
        ,
        WAIT_ACK
`endif
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] presc;      // step-grid prescaler (held in WAIT_ACK)
    logic [PRESC_W-1:0] el_presc;   // elapsed-time prescaler (never held)
    logic [CNT_W-1:0]   us_cnt;     // microseconds since last step
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   nsteps_q;
    logic               accept;
    logic               step_due;
    logic               last_step;

    // Saturating increment for the elapsed-microsecond counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_ONES) ? v : v + CNT_ONE;
    endfunction

    // A start only counts in IDLE and only when stop is not also asserted.
    assign accept    = (state == IDLE) && start && !stop;
    assign step_due  = (presc == PRESC_MAX) && (us_cnt == period_q - CNT_ONE);
    assign last_step = (nsteps_q != '0) && (step_idx + CNT_ONE == nsteps_q);

    // Elapsed time keeps running through WAIT_ACK, so it has its own prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            el_presc   <= '0;
            us_elapsed <= '0;
        end else if (accept) begin
            el_presc   <= '0;
            us_elapsed <= '0;
        end else if (state != IDLE && !stop) begin
            if (el_presc == PRESC_MAX) begin
                el_presc   <= '0;
                us_elapsed <= sat_inc(us_elapsed);
            end else begin
                el_presc <= el_presc + 1'b1;
            end
        end
    end

    // Main control FSM: capture, step-grid timing, completion and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            us_cnt     <= '0;
            period_q   <= '0;
            nsteps_q   <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            step_idx   <= '0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A zero period would never fire; treat it as 1 us.
                        period_q <= (period_us == '0) ? CNT_ONE : period_us;
                        nsteps_q <= num_steps;
                        step_idx <= '0;
                        presc    <= '0;
                        us_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort wins over a step that falls due on this edge.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (presc == PRESC_MAX) begin
                        presc <= '0;
                        if (step_due) begin
                            // Restart the us count on each step: no drift.
                            us_cnt     <= '0;
                            step_pulse <= 1'b1;
                            step_idx   <= step_idx + CNT_ONE;
                            if (last_step) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
`ifdef TS_ACK_EN
                                state <= WAIT_ACK;
`else
                                state <= RUN;
`endif
                            end
                        end else begin
                            us_cnt <= us_cnt + CNT_ONE;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
`ifdef TS_ACK_EN
                WAIT_ACK: begin
                    presc  <= '0;
                    us_cnt <= '0;
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (step_ack && !step_pulse) begin
                        // An ack coincident with the pulse itself is too early.
                        state <= RUN;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_us_timestep_gen.sv
// tb_us_timestep_gen: randomized and directed bench for us_timestep_gen.
// Expected outputs come from a closed-form model of time-since-start.
module tb_us_timestep_gen;

    localparam int C = 125;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period_us = '0;
    logic [31:0] num_steps = '0;
    logic        busy;
    logic        step_pulse;
    logic [31:0] step_idx;
    logic        done;
    logic [31:0] us_elapsed;
`ifdef TS_ACK_EN
    logic        step_ack = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    us_timestep_gen #(.CLK_PER_US(C), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .period_us  (period_us),
        .num_steps  (num_steps),
        .busy       (busy),
        .step_pulse (step_pulse),
        .step_idx   (step_idx),
        .done       (done),
        .us_elapsed (us_elapsed)
`ifdef TS_ACK_EN
        ,
        .step_ack   (step_ack)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs t edges after the accepted start, no stop applied.
    task automatic model_check(input longint t, input longint pe, input longint n);
        longint pc, tend, te;
        bit     e_pulse, e_done, e_busy;
        pc      = pe * C;
        tend    = n * pc;
        te      = (n != 0 && t > tend) ? tend : t;
        e_pulse = (t > 0) && (t % pc == 0) && (n == 0 || t <= tend);
        e_done  = (n != 0) && (t == tend);
        e_busy  = (n == 0) || (t < tend);
        check("step_pulse", step_pulse, e_pulse);
        check("done", done, e_done);
        check("busy", busy, e_busy);
        check("step_idx", step_idx, te / pc);
        check("us_elapsed", us_elapsed, te / C);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pulse"}, step_pulse, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_idx"}, step_idx, 0);
        check({tag, "_el"}, us_elapsed, 0);
    endtask

    // One complete run; with noise, inputs are scrambled and start is re-pulsed.
    task automatic run(input int p, input int n, input bit noise);
        longint pe, tend;
        pe   = (p == 0) ? 1 : p;
        tend = longint'(n) * pe * C;
        period_us = p;
        num_steps = n;
        start     = 1'b1;
        tick();
        start = 1'b0;
        model_check(0, pe, n);
        for (longint t = 1; t <= tend + 4; t++) begin
            if (noise) begin
                if (t <= tend && $urandom_range(0, 39) == 0) start = 1'b1;
                period_us = $urandom;
                num_steps = $urandom;
            end
            tick();
            start = 1'b0;
            model_check(t, pe, n);
        end
        period_us = '0;
        num_steps = '0;
    endtask

    initial begin
        int nmax;
        #1;
        check_all_zero("reset");
        #20 rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);

`ifdef TS_ACK_EN
        nmax = 1;
`else
        nmax = 3;
        // Basic run: pulses at 250, 500, 750; done with the third.
        run(2, 3, 1'b0);
        check("basic_el_hold", us_elapsed, 6);
`endif
        run(0, 1, 1'b0);
        for (int i = 0; i < 6; i++)
            run($urandom_range(0, 3), $urandom_range(1, nmax), 1'b1);

`ifndef TS_ACK_EN
        // Zero period, run forever: 10 pulses then stop.
        period_us = 0;
        num_steps = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (longint t = 1; t <= 10 * C; t++) begin
            tick();
            model_check(t, 1, 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("inf_stop_busy", busy, 0);
        check("inf_stop_done", done, 0);
        check("inf_stop_idx", step_idx, 10);
        for (int i = 0; i < 3; i++) tick();
        check("inf_hold_idx", step_idx, 10);
        check("inf_hold_busy", busy, 0);
`endif

        // Stop on the edge the second pulse is due.
        period_us = 1;
        num_steps = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (longint t = 1; t < 2 * C; t++) begin
            tick();
            if (t == C || t == 2 * C - 1) model_check(t, 1, 5);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("coll_pulse", step_pulse, 0);
        check("coll_done", done, 0);
        check("coll_busy", busy, 0);
        check("coll_idx", step_idx, 1);
        for (int i = 0; i < 2 * C; i++) begin
            tick();
            check("coll_no_pulse", step_pulse | done | busy, 0);
        end

        // start together with stop in IDLE is ignored.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 0);
        tick();
        check("ss_busy2", busy, 0);
        check("ss_idx", step_idx, 1);

`ifndef TS_ACK_EN
        // Asynchronous reset while running at step_idx=3.
        period_us = 1;
        num_steps = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 400; t++) tick();
        check("pre_rst_idx", step_idx, 3);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("post_rst");
`endif

`ifdef TS_ACK_EN
        // Ack mode: P=1, N=2; ack 40 cycles after the first pulse.
        begin
            longint a;
            period_us = 1;
            num_steps = 2;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (longint t = 1; t <= C; t++) begin
                tick();
                if (t == C) model_check(t, 1, 2);
            end
            step_ack = 1'b1;   // coincident with the pulse: ignored
            tick();
            step_ack = 1'b0;
            for (longint t = C + 1; t < C + 40; t++) begin
                check("ack_wait_pulse", step_pulse, 0);
                check("ack_wait_busy", busy, 1);
                tick();
            end
            step_ack = 1'b1;
            tick();
            step_ack = 1'b0;
            a = C + 41;
            for (longint t = a + 1; t < a + C; t++) begin
                if (t == a + 50) step_ack = 1'b1;  // in RUN: ignored
                tick();
                step_ack = 1'b0;
                check("ack_run_pulse", step_pulse, 0);
            end
            tick();
            check("ack_pulse2", step_pulse, 1);
            check("ack_done", done, 1);
            check("ack_idx", step_idx, 2);
            check("ack_el", us_elapsed, (a + C) / C);
            tick();
            check("ack_busy", busy, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/us_timestep_gen.md
Name: us_timestep_gen

Overview:
- Microsecond-based timestep generator on the datapath clock.
- Once started, emits a one-cycle step_pulse every period_us microseconds, for num_steps steps or indefinitely, then signals done.
- Transmit-side counterpart of the round-trip timer: it paces sends on a programmed microsecond grid, while the timer measures elapsed microseconds.

Parameters:
- CLK_PER_US, 125, clock cycles per microsecond (125 MHz clk); legal range 2..65535.
- CNT_W, 32, width of the period, step and elapsed counters.

Ports:
- clk  input  1  datapath clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- stop  input  1  one-cycle abort; sampled in any state.
- period_us  input  CNT_W  step period in us; captured on accepted start.
- num_steps  input  CNT_W  number of steps; 0 = run until stop; captured on accepted start.
- busy  output  1  high from accepted start until done or abort.
- step_pulse  output  1  one-cycle timestep strobe.
- step_idx  output  CNT_W  count of step_pulses issued in the current run.
- done  output  1  one-cycle strobe when num_steps steps have completed.
- us_elapsed  output  CNT_W  whole microseconds since the accepted start; saturates at all-ones.
- step_ack  input  1  only present with TS_ACK_EN.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, prescaler=0, us counter=0.
  - All outputs 0: busy, step_pulse, done, step_idx, us_elapsed.
- All outputs are registered.
- States: IDLE, RUN, WAIT_ACK (WAIT_ACK only with TS_ACK_EN).
- IDLE:
  - Start sampled high at edge E0 (with stop low): capture period_us (a value of 0 is treated as 1) and num_steps.
  - At E0: clear step_idx, us_elapsed, prescaler and us counter; set busy=1; go to RUN.
  - step_idx and us_elapsed hold their last values in IDLE until the next start.
- RUN:
  - Prescaler counts 0..CLK_PER_US-1 and wraps.
  - Each wrap is a us tick: us counter +1, us_elapsed +1 (saturating).
  - step_pulse=1 for exactly the cycle beginning at edge E0 + k·P·CLK_PER_US, where k=1,2,… and P is the captured period.
  - The us counter resets on each step, so there is no cumulative drift.
  - step_idx increments on the same edge that raises step_pulse, so it reads k while step_pulse is high.
- Completion (num_steps≠0):
  - On the edge raising step_pulse with step_idx becoming num_steps: done=1 and busy=0 on that same edge; FSM goes to IDLE.
  - done and the final step_pulse are coincident, one cycle each.
- num_steps=0: runs until stop; step_idx wraps modulo 2^CNT_W; done is never asserted.
- stop:
  - Sampled high in RUN or WAIT_ACK: FSM goes to IDLE, busy=0 next edge.
  - No step_pulse and no done on that edge, even if a step was due (stop wins).
- start in IDLE together with stop: start is ignored and FSM stays in IDLE.
- start while busy: ignored; captured values are unchanged.
- Input changes on period_us/num_steps mid-run: no effect.

Optional Feature:
- Macro: TS_ACK_EN.
- Defined:
  - step_ack port exists.
  - After every non-final step_pulse, FSM enters WAIT_ACK.
  - In WAIT_ACK the prescaler and us counter are held at 0; us_elapsed keeps counting.
  - step_ack sampled high at edge A: return to RUN; the next step_pulse is at edge A + P·CLK_PER_US.
  - step_ack high in the same cycle as step_pulse is ignored.
  - step_ack outside WAIT_ACK is ignored.
  - The final step goes straight to done/IDLE with no ack needed.
- Undefined: no step_ack port; free-running periodic pulses as described under Behaviour.

Test Plan:
- Reset mid-run: assert rst_n=0 for 1 cycle while busy at step_idx=3 → all outputs 0 immediately (async); FSM in IDLE.
- Basic run: period_us=2, num_steps=3, start at E0 → step_pulse at E0+250, +500, +750; step_idx 1,2,3; done with the third pulse; busy low after E0+750; us_elapsed=6.
- Zero period / infinite run: period_us=0, num_steps=0 → pulses every 125 cycles; 10 pulses then stop → no done, busy=0, step_idx holds 10.
- Stop collision: period_us=1, num_steps=5, stop on the cycle the 2nd pulse is due → no 2nd pulse, no done, step_idx=1.
- Ignored inputs:
  - start while busy → no effect.
  - start+stop together in IDLE → busy stays 0.
  - period_us changed mid-run → pulse spacing unchanged.
- TS_ACK_EN: period_us=1, num_steps=2, step_ack sent 40 cycles after the 1st pulse (edge A) → 2nd pulse at A+125, done with it; ack pulsed during RUN → ignored.
